// File: rtl/load_store_unit_pkg.sv
// Shared encodings and helpers for the load/store unit: opcodes, FSM states and
// alignment/load-class decode.
package load_store_unit_pkg;

  localparam int unsigned MemAddrWDefault = 12;

  typedef enum logic [2:0] {
    OpLw  = 3'd0,
    OpLh  = 3'd1,
    OpLhu = 3'd2,
    OpLb  = 3'd3,
    OpLbu = 3'd4,
    OpSw  = 3'd5,
    OpSh  = 3'd6,
    OpSb  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

  function automatic logic is_load(op_e op);
    return (op == OpLw) || (op == OpLh) || (op == OpLhu) || (op == OpLb) || (op == OpLbu);
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (op)
      OpLw, OpSw:        mis = (addr_lo != 2'b00);
      OpLh, OpLhu, OpSh: mis = addr_lo[0];
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: extracts and extends load data from a memory word,
// and merges store data into the word for partial stores.
module lsu_byte_lane
  import load_store_unit_pkg::*;
(
  input  op_e         i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = i_rdata;
    case (i_op)
      OpLh:    o_load_data = {{16{w_half[15]}}, w_half};
      OpLhu:   o_load_data = {16'h0000, w_half};
      OpLb:    o_load_data = {{24{w_byte[7]}}, w_byte};
      OpLbu:   o_load_data = {24'h000000, w_byte};
      default: o_load_data = i_rdata;
    endcase
  end

  // Untouched lanes keep the word just read, so partial stores preserve neighbours.
  always_comb begin
    o_merge_data = i_rdata;
    case (i_op)
      OpSw: o_merge_data = i_sdata;
      OpSh: begin
        if (i_addr_lo[1]) o_merge_data[31:16] = i_sdata[15:0];
        else              o_merge_data[15:0]  = i_sdata[15:0];
      end
      OpSb: o_merge_data[{i_addr_lo, 3'b000} +: 8] = i_sdata[7:0];
      default: o_merge_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: single-word memory port, read-modify-write for
// halfword/byte stores, alignment and range checking.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_ADDR_W = MemAddrWDefault
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_address,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_error,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [31:0] i_mem_read_data
);

  state_e      r_state;
  state_e      w_state_d;
  op_e         r_op;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_sdata;
  logic [31:0] r_load_data;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_error;

  op_e         w_op_in;
  logic        w_accept;
  logic        w_oor;
  logic        w_err;
  logic [31:0] w_lane_load;
  logic [31:0] w_lane_merge;

  assign w_op_in  = op_e'(i_op);
  assign w_accept = (r_state == StIdle) && i_start;
  assign w_oor    = (i_address >> MEM_ADDR_W) != 32'd0;
  assign w_err    = w_oor || is_misaligned(w_op_in, i_address[1:0]);

  lsu_byte_lane u_lane (
    .i_op         (r_op),
    .i_addr_lo    (r_addr_lo),
    .i_rdata      (i_mem_read_data),
    .i_sdata      (r_sdata),
    .o_load_data  (w_lane_load),
    .o_merge_data (w_lane_merge)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_err)                w_state_d = StDone;
          else if (w_op_in == OpSw) w_state_d = StWr;
          else                      w_state_d = StRd;
        end
      end
      StRd:    w_state_d = is_load(r_op) ? StDone : StWr;
      StWr:    w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_op        <= OpLw;
      r_addr_lo   <= 2'b00;
      r_sdata     <= 32'h0;
      r_load_data <= 32'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op      <= w_op_in;
        r_addr_lo <= i_address[1:0];
        r_sdata   <= i_store_data;
        r_error   <= w_err;
        // Errored accesses leave the memory port untouched.
        if (!w_err) begin
          r_mem_addr <= {i_address[31:2], 2'b00};
          if (w_op_in == OpSw) r_mem_wdata <= i_store_data;
        end
      end
      if (r_state == StRd) begin
        if (is_load(r_op)) r_load_data <= w_lane_load;
        else               r_mem_wdata <= w_lane_merge;
      end
      if (r_state == StDone) r_error <= 1'b0;
    end
  end

  assign o_busy           = (r_state != StIdle);
  assign o_done           = (r_state == StDone);
  assign o_error          = r_error;
  assign o_load_data      = r_load_data;
  assign o_mem_address    = r_mem_addr;
  assign o_mem_write_data = r_mem_wdata;
  assign o_mem_read       = (r_state == StRd);
  assign o_mem_write      = (r_state == StWr);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of single accesses plus
// reset-abort and start-while-busy sequences against a behavioural memory.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        busy, done, err, mem_write, mem_read;
  logic [31:0] load_data, mem_addr, mem_wdata;
  wire  [31:0] mem_rdata;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_done = 0;
  int n_viol = 0;

  load_store_unit #(.MEM_ADDR_W(12)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_op             (op),
    .i_address        (addr),
    .i_store_data     (sdata),
    .o_busy           (busy),
    .o_done           (done),
    .o_load_data      (load_data),
    .o_error          (err),
    .o_mem_address    (mem_addr),
    .o_mem_write_data (mem_wdata),
    .o_mem_write      (mem_write),
    .o_mem_read       (mem_read),
    .i_mem_read_data  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'hzzzzzzzz;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_write) n_wr <= n_wr + 1;
    if (mem_read) n_rd <= n_rd + 1;
    if (done) n_done <= n_done + 1;
    if ((mem_read && mem_write) || ((mem_read || mem_write) && (!busy || done)))
      n_viol <= n_viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  function automatic vec_t mk(logic [2:0] o, logic [31:0] a, logic [31:0] s, logic [31:0] d,
                              logic e, int l, logic [31:0] w);
    vec_t v;
    v.op = o; v.addr = a; v.sdata = s; v.exp_data = d;
    v.exp_err = e; v.exp_lat = l; v.exp_word = w;
    return v;
  endfunction

  // Issues one request and returns cycles from the accepting edge to Done (capped).
  task automatic access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] s,
                        output int lat, output logic e_at_done);
    @(negedge clk);
    op = o; addr = a; sdata = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    e_at_done = err;
    @(posedge clk); #1;
  endtask

  vec_t vecs[15];

  initial begin
    int lat;
    logic e;
    int wr0, rd0, dn0;
    logic is_st;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'h8899AABB;
    mem[32'h20 >> 2] = 32'h11223344;
    mem[32'h04 >> 2] = 32'h55555555;
    mem[32'h40 >> 2] = 32'hA5A5A5A5;

    vecs[0]  = mk(OpLb,  32'h11,   32'h0,        32'hFFFFFFAA, 1'b0, 2, 32'h0);
    vecs[1]  = mk(OpLhu, 32'h12,   32'h0,        32'h00008899, 1'b0, 2, 32'h0);
    vecs[2]  = mk(OpLh,  32'h12,   32'h0,        32'hFFFF8899, 1'b0, 2, 32'h0);
    vecs[3]  = mk(OpLw,  32'h10,   32'h0,        32'h8899AABB, 1'b0, 2, 32'h0);
    vecs[4]  = mk(OpLbu, 32'h13,   32'h0,        32'h00000088, 1'b0, 2, 32'h0);
    vecs[5]  = mk(OpLb,  32'h10,   32'h0,        32'hFFFFFFBB, 1'b0, 2, 32'h0);
    vecs[6]  = mk(OpLh,  32'h10,   32'h0,        32'hFFFFAABB, 1'b0, 2, 32'h0);
    vecs[7]  = mk(OpSb,  32'h22,   32'h000000EE, 32'h0,        1'b0, 3, 32'h11EE3344);
    vecs[8]  = mk(OpSh,  32'h20,   32'h1234CAFE, 32'h0,        1'b0, 3, 32'h11EECAFE);
    vecs[9]  = mk(OpSw,  32'h24,   32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF);
    vecs[10] = mk(OpSw,  32'h06,   32'hCCCCCCCC, 32'h0,        1'b1, 1, 32'h55555555);
    vecs[11] = mk(OpLh,  32'h11,   32'h0,        32'h0,        1'b1, 1, 32'h0);
    vecs[12] = mk(OpLw,  32'h1000, 32'h0,        32'h0,        1'b1, 1, 32'h0);
    vecs[13] = mk(OpLb,  32'h23,   32'h0,        32'h00000011, 1'b0, 2, 32'h0);
    vecs[14] = mk(OpLbu, 32'h12,   32'h0,        32'h00000099, 1'b0, 2, 32'h0);

    rst_n = 1'b0; start = 1'b0; op = 3'd0; addr = 32'h0; sdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {29'h0, busy, done, err}, 32'h0);
    check("reset_mem_ctrl", {30'h0, mem_read, mem_write}, 32'h0);
    check("reset_load_data", load_data, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      wr0 = n_wr; rd0 = n_rd;
      is_st = (vecs[i].op == OpSw) || (vecs[i].op == OpSh) || (vecs[i].op == OpSb);
      access(vecs[i].op, vecs[i].addr, vecs[i].sdata, lat, e);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_error", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_busy_after", i), {31'h0, busy}, 32'h0);
      if (!is_st && !vecs[i].exp_err)
        check($sformatf("v%0d_load_data", i), load_data, vecs[i].exp_data);
      if (is_st)
        check($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[11:2]], vecs[i].exp_word);
      check($sformatf("v%0d_writes", i), n_wr - wr0, (is_st && !vecs[i].exp_err) ? 1 : 0);
      check($sformatf("v%0d_reads", i), n_rd - rd0,
            (vecs[i].exp_err || vecs[i].op == OpSw) ? 0 : 1);
    end

    // Reset during RD of an SH must abort cleanly.
    wr0 = n_wr; dn0 = n_done;
    @(negedge clk);
    op = OpSh; addr = 32'h40; sdata = 32'h0000FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_in_rd", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_ctrl_zero", {26'h0, busy, done, err, mem_read, mem_write, 1'b0}, 32'h0);
    check("abort_load_data", load_data, 32'h0);
    check("abort_mem_addr", mem_addr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_write", n_wr - wr0, 0);
    check("abort_no_done", n_done - dn0, 0);
    check("abort_mem_kept", mem[32'h40 >> 2], 32'hA5A5A5A5);
    check("abort_idle", {31'h0, busy}, 32'h0);

    // A second Start while busy must be ignored.
    wr0 = n_wr; dn0 = n_done;
    @(negedge clk);
    op = OpSw; addr = 32'h30; sdata = 32'h11111111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
    @(negedge clk);
    op = OpSw; addr = 32'h34; sdata = 32'h22222222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("busy_one_done", n_done - dn0, 1);
    check("busy_one_write", n_wr - wr0, 1);
    check("busy_first_mem", mem[32'h30 >> 2], 32'h11111111);
    check("busy_second_mem", mem[32'h34 >> 2], 32'h0);

    check("mem_ctrl_rules", n_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
